// File: rtl/memory_stage.sv
// memory_stage: executes loads/stores against a word-addressed memory and hands
// a one-cycle-valid, already-extended result bundle to write-back.
module memory_stage #(
   parameter int XLEN      = 32,
   parameter int IID_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [XLEN-1:0]      in_inst,
   input  logic [IID_WIDTH-1:0] in_inst_id,
   input  logic                 in_rf_wen,
   input  logic [4:0]           in_reg_addr,
   input  logic [XLEN-1:0]      in_alu_result,
   input  logic                 in_mem_ren,
   input  logic                 in_mem_wen,
   input  logic [2:0]           in_mem_funct3,
   input  logic [XLEN-1:0]      in_store_data,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [XLEN-1:0]      mem_req_addr,
   output logic                 mem_req_wen,
   output logic [XLEN-1:0]      mem_req_wdata,
   output logic [3:0]           mem_req_wmask,
   input  logic                 mem_resp_valid,
   input  logic [XLEN-1:0]      mem_resp_rdata,
   output logic                 wb_valid,
   output logic [XLEN-1:0]      wb_pc,
   output logic [XLEN-1:0]      wb_inst,
   output logic [IID_WIDTH-1:0] wb_inst_id,
   output logic                 wb_rf_wen,
   output logic [4:0]           wb_reg_addr,
   output logic [XLEN-1:0]      wb_wdata,
   output logic                 wb_misaligned
);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t                r_state;
   logic [XLEN-1:0]       r_pc, r_inst, r_addr, r_wdata;
   logic [IID_WIDTH-1:0]  r_iid;
   logic                  r_rf_wen, r_wen;
   logic [4:0]            r_rd;
   logic [2:0]            r_f3;
   logic [3:0]            r_wmask;
   logic [1:0]            w_off;
   logic                  w_mem, w_b, w_h, w_misal, w_done, r_b, r_h, r_uns;
   logic [XLEN-1:0]       w_st_wdata, w_shift, w_ld;
   logic [3:0]            w_st_wmask;
   // Funct3 encodings other than B/H/BU/HU all collapse to word access.
   assign w_off      = in_alu_result[1:0];
   assign w_mem      = in_mem_ren | in_mem_wen;
   assign w_b        = in_mem_funct3[1:0] == 2'b00;
   assign w_h        = in_mem_funct3[1:0] == 2'b01;
   assign w_misal    = (w_h & w_off[0]) | (!w_b && !w_h && w_off != 2'b00);
   assign w_st_wdata = w_b ? {4{in_store_data[7:0]}} : w_h ? {2{in_store_data[15:0]}} : in_store_data;
   assign w_st_wmask = w_b ? 4'b0001 << w_off : w_h ? 4'b0011 << w_off : 4'b1111;
   assign r_b        = r_f3[1:0] == 2'b00;
   assign r_h        = r_f3[1:0] == 2'b01;
   assign r_uns      = r_f3[2] & ~r_f3[1];
   assign w_shift    = mem_resp_rdata >> {r_addr[1:0], 3'b000};
   assign w_ld       = r_b ? {{24{~r_uns & w_shift[7]}}, w_shift[7:0]} :
                       r_h ? {{16{~r_uns & w_shift[15]}}, w_shift[15:0]} : w_shift;
   assign w_done     = (r_state == REQ && mem_req_ready && r_wen) || (r_state == RESP && mem_resp_valid);
   assign in_ready      = r_state == IDLE;
   assign mem_req_valid = r_state == REQ;
   assign mem_req_addr  = {r_addr[XLEN-1:2], 2'b00};
   assign mem_req_wen   = r_wen;
   assign mem_req_wdata = r_wdata;
   assign mem_req_wmask = r_wmask;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_pc          <= '0;
         r_inst        <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_iid         <= '0;
         r_rf_wen      <= 1'b0;
         r_wen         <= 1'b0;
         r_rd          <= '0;
         r_f3          <= '0;
         r_wmask       <= '0;
         wb_valid      <= 1'b0;
         wb_pc         <= '0;
         wb_inst       <= '0;
         wb_inst_id    <= '0;
         wb_rf_wen     <= 1'b0;
         wb_reg_addr   <= '0;
         wb_wdata      <= '0;
         wb_misaligned <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         if (r_state == IDLE && in_valid) begin
            if (!w_mem || w_misal) begin
               wb_valid      <= 1'b1;
               wb_pc         <= in_pc;
               wb_inst       <= in_inst;
               wb_inst_id    <= in_inst_id;
               wb_rf_wen     <= in_rf_wen & ~w_mem;
               wb_reg_addr   <= in_reg_addr;
               wb_wdata      <= in_alu_result;
               wb_misaligned <= w_mem;
            end else begin
               r_state  <= REQ;
               r_pc     <= in_pc;
               r_inst   <= in_inst;
               r_iid    <= in_inst_id;
               r_rf_wen <= in_rf_wen;
               r_rd     <= in_reg_addr;
               r_addr   <= in_alu_result;
               r_wen    <= in_mem_wen;
               r_f3     <= in_mem_funct3;
               r_wdata  <= w_st_wdata;
               r_wmask  <= w_st_wmask;
            end
         end
         if (r_state == REQ && mem_req_ready)
            r_state <= r_wen ? IDLE : RESP;
         if (r_state == RESP && mem_resp_valid)
            r_state <= IDLE;
         if (w_done) begin
            wb_valid      <= 1'b1;
            wb_pc         <= r_pc;
            wb_inst       <= r_inst;
            wb_inst_id    <= r_iid;
            wb_rf_wen     <= r_rf_wen;
            wb_reg_addr   <= r_rd;
            wb_wdata      <= r_wen ? r_addr : w_ld;
            wb_misaligned <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed scenario tasks with hand-computed expectations.
module tb_memory_stage;
   logic        clk = 0, reset = 1;
   logic        in_valid = 0, in_ready, in_rf_wen = 0, in_mem_ren = 0, in_mem_wen = 0;
   logic [31:0] in_pc = 0, in_inst = 0, in_alu_result = 0, in_store_data = 0;
   logic [63:0] in_inst_id = 0;
   logic [4:0]  in_reg_addr = 0;
   logic [2:0]  in_mem_funct3 = 0;
   logic        mem_req_valid, mem_req_ready = 0, mem_req_wen, mem_resp_valid = 0;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = 0;
   logic [3:0]  mem_req_wmask;
   logic        wb_valid, wb_rf_wen, wb_misaligned;
   logic [31:0] wb_pc, wb_inst, wb_wdata;
   logic [63:0] wb_inst_id;
   logic [4:0]  wb_reg_addr;
   int passed = 0, total = 0;

   memory_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .in_inst_id(in_inst_id), .in_rf_wen(in_rf_wen),
      .in_reg_addr(in_reg_addr), .in_alu_result(in_alu_result), .in_mem_ren(in_mem_ren),
      .in_mem_wen(in_mem_wen), .in_mem_funct3(in_mem_funct3), .in_store_data(in_store_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_inst_id(wb_inst_id),
      .wb_rf_wen(wb_rf_wen), .wb_reg_addr(wb_reg_addr), .wb_wdata(wb_wdata),
      .wb_misaligned(wb_misaligned)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic rfw,
                        input logic [31:0] alu, input logic ren, input logic wen,
                        input logic [2:0] f3, input logic [31:0] sd);
      in_valid = 1; in_pc = pc; in_inst = pc ^ 32'h5A5A_0000; in_inst_id = {32'd0, pc};
      in_reg_addr = rd; in_rf_wen = rfw; in_alu_result = alu; in_mem_ren = ren;
      in_mem_wen = wen; in_mem_funct3 = f3; in_store_data = sd;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else passed++;
      total++; if (mem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b exp 0", mem_req_valid); else passed++;
      total++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid got %b exp 0", wb_valid); else passed++;
      total++; if (wb_wdata !== 32'h0) $display("FAIL rst_wb_wdata got %h exp 0", wb_wdata); else passed++;
      total++; if (wb_misaligned !== 1'b0) $display("FAIL rst_misal got %b exp 0", wb_misaligned); else passed++;
      @(negedge clk); reset = 0;
   endtask

   task automatic test_alu_back_to_back;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(32'h1000 + 4 * i, 5'd5, 1'b1, 32'h1234, 0, 0, 3'd0, 0);
         total++; if (in_ready !== 1'b1) $display("FAIL alu_in_ready[%0d] got %b exp 1", i, in_ready); else passed++;
         @(posedge clk); #1;
         total++; if (wb_valid !== 1'b1) $display("FAIL alu_valid[%0d] got %b exp 1", i, wb_valid); else passed++;
         total++; if (wb_wdata !== 32'h1234) $display("FAIL alu_wdata[%0d] got %h exp 1234", i, wb_wdata); else passed++;
         total++; if (wb_reg_addr !== 5'd5) $display("FAIL alu_rd[%0d] got %0d exp 5", i, wb_reg_addr); else passed++;
         total++; if (wb_pc !== 32'h1000 + 4 * i) $display("FAIL alu_pc[%0d] got %h exp %h", i, wb_pc, 32'h1000 + 4 * i); else passed++;
      end
      in_valid = 0;
      @(posedge clk); #1;
      total++; if (wb_valid !== 1'b0) $display("FAIL alu_valid_drop got %b exp 0", wb_valid); else passed++;
   endtask

   task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
      @(negedge clk);
      drive(32'h2000, 5'd7, 1'b1, addr, 1, 0, f3, 0);
      @(posedge clk); #1;
      in_valid = 0;
      total++; if (mem_req_valid !== 1'b1) $display("FAIL %s_req_valid got %b exp 1", nm, mem_req_valid); else passed++;
      total++; if (mem_req_addr !== {addr[31:2], 2'b00}) $display("FAIL %s_req_addr got %h exp %h", nm, mem_req_addr, {addr[31:2], 2'b00}); else passed++;
      total++; if (mem_req_wen !== 1'b0) $display("FAIL %s_req_wen got %b exp 0", nm, mem_req_wen); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL %s_in_ready got %b exp 0", nm, in_ready); else passed++;
      mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0;
      total++; if (mem_req_valid !== 1'b0) $display("FAIL %s_resp_req_valid got %b exp 0", nm, mem_req_valid); else passed++;
      mem_resp_valid = 1; mem_resp_rdata = rdata;
      @(posedge clk); #1;
      mem_resp_valid = 0;
      total++; if (wb_valid !== 1'b1) $display("FAIL %s_wb_valid got %b exp 1", nm, wb_valid); else passed++;
      total++; if (wb_wdata !== exp) $display("FAIL %s_wb_wdata got %h exp %h", nm, wb_wdata, exp); else passed++;
      total++; if (wb_rf_wen !== 1'b1) $display("FAIL %s_wb_rf_wen got %b exp 1", nm, wb_rf_wen); else passed++;
   endtask

   task automatic test_store_wait;
      @(negedge clk);
      drive(32'h3000, 5'd0, 1'b0, 32'h202, 0, 1, 3'd1, 32'h1234_ABCD);
      @(posedge clk); #1;
      in_valid = 0;
      for (int i = 0; i < 3; i++) begin
         total++; if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1 || mem_req_addr !== 32'h200)
            $display("FAIL sh_req[%0d] got v=%b w=%b a=%h exp v=1 w=1 a=200", i, mem_req_valid, mem_req_wen, mem_req_addr); else passed++;
         total++; if (mem_req_wmask !== 4'b1100 || mem_req_wdata !== 32'hABCD_ABCD)
            $display("FAIL sh_lane[%0d] got m=%b d=%h exp m=1100 d=abcdabcd", i, mem_req_wmask, mem_req_wdata); else passed++;
         total++; if (in_ready !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL sh_wait[%0d] got rdy=%b wbv=%b exp 0 0", i, in_ready, wb_valid); else passed++;
         @(posedge clk); #1;
      end
      mem_req_ready = 1;
      #1;
      total++; if (in_ready !== 1'b0 || mem_req_valid !== 1'b1) $display("FAIL sh_hs got rdy=%b v=%b exp 0 1", in_ready, mem_req_valid); else passed++;
      @(posedge clk); #1;
      mem_req_ready = 0;
      total++; if (wb_valid !== 1'b1) $display("FAIL sh_wb_valid got %b exp 1", wb_valid); else passed++;
      total++; if (wb_rf_wen !== 1'b0) $display("FAIL sh_wb_rf_wen got %b exp 0", wb_rf_wen); else passed++;
      total++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0) $display("FAIL sh_idle got rdy=%b v=%b exp 1 0", in_ready, mem_req_valid); else passed++;
      @(posedge clk); #1;
      total++; if (wb_valid !== 1'b0) $display("FAIL sh_wb_pulse got %b exp 0", wb_valid); else passed++;
   endtask

   task automatic test_misaligned;
      @(negedge clk);
      drive(32'h4000, 5'd9, 1'b1, 32'h101, 1, 0, 3'd2, 0);
      @(posedge clk); #1;
      in_valid = 0;
      total++; if (wb_valid !== 1'b1) $display("FAIL mis_wb_valid got %b exp 1", wb_valid); else passed++;
      total++; if (wb_misaligned !== 1'b1) $display("FAIL mis_flag got %b exp 1", wb_misaligned); else passed++;
      total++; if (wb_rf_wen !== 1'b0) $display("FAIL mis_rf_wen got %b exp 0", wb_rf_wen); else passed++;
      total++; if (mem_req_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mis_noreq got v=%b rdy=%b exp 0 1", mem_req_valid, in_ready); else passed++;
   endtask

   task automatic test_delayed_load;
      @(negedge clk);
      drive(32'h5000, 5'd11, 1'b1, 32'h300, 1, 0, 3'd1, 0);
      @(posedge clk); #1;
      in_valid = 0; mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++; if (wb_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL lh_wait[%0d] got wbv=%b rdy=%b exp 0 0", i, wb_valid, in_ready); else passed++;
      end
      mem_resp_valid = 1; mem_resp_rdata = 32'h0000_8001;
      @(posedge clk); #1;
      mem_resp_valid = 0;
      total++; if (wb_valid !== 1'b1) $display("FAIL lh_wb_valid got %b exp 1", wb_valid); else passed++;
      total++; if (wb_wdata !== 32'hFFFF_8001) $display("FAIL lh_wdata got %h exp ffff8001", wb_wdata); else passed++;
      total++; if (wb_misaligned !== 1'b0) $display("FAIL lh_misal got %b exp 0", wb_misaligned); else passed++;
      mem_resp_valid = 1;
      @(posedge clk); #1;
      mem_resp_valid = 0;
      total++; if (wb_valid !== 1'b0) $display("FAIL stray_idle got %b exp 0", wb_valid); else passed++;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      drive(32'h6000, 5'd12, 1'b1, 32'h400, 1, 0, 3'd2, 0);
      @(posedge clk); #1;
      in_valid = 0; mem_req_ready = 1;
      @(posedge clk); #1;
      mem_req_ready = 0;
      reset = 1;
      #1;
      total++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0) $display("FAIL rmid_state got rdy=%b v=%b exp 1 0", in_ready, mem_req_valid); else passed++;
      total++; if (wb_valid !== 1'b0 || wb_wdata !== 32'h0 || wb_reg_addr !== 5'd0) $display("FAIL rmid_wb got v=%b d=%h rd=%0d exp 0 0 0", wb_valid, wb_wdata, wb_reg_addr); else passed++;
      @(negedge clk); reset = 0;
      mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_resp_valid = 0;
      total++; if (wb_valid !== 1'b0) $display("FAIL rmid_stray got %b exp 0", wb_valid); else passed++;
      @(negedge clk);
      drive(32'h7000, 5'd3, 1'b1, 32'h55AA, 0, 0, 3'd0, 0);
      @(posedge clk); #1;
      in_valid = 0;
      total++; if (wb_valid !== 1'b1 || wb_wdata !== 32'h55AA || wb_reg_addr !== 5'd3)
         $display("FAIL rmid_next got v=%b d=%h rd=%0d exp 1 55aa 3", wb_valid, wb_wdata, wb_reg_addr); else passed++;
   endtask

   initial begin
      test_reset;
      test_alu_back_to_back;
      test_load("lb", 3'd0, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
      test_load("lbu", 3'd4, 32'h103, 32'h80FF_0000, 32'h0000_0080);
      test_load("lhu", 3'd5, 32'h102, 32'h9234_0000, 32'h0000_9234);
      test_load("lw", 3'd2, 32'h104, 32'hCAFE_F00D, 32'hCAFE_F00D);
      test_store_wait;
      test_misaligned;
      test_delayed_load;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
